i2s_frame_sequencer: RTL and testbench

Master-side source for the LED serial stream. Reads pixel words from a double-buffered frame memory and emits, for each display row, a 16-bit header followed by the row payload on `i2s_data`, cycling through all rows of a frame continuously. It sequences the shared serial bus that every tile receiver taps. Bank swaps are performed only on frame boundaries, under a req/ack handshake with the frame writer.

---
 rtl/i2s_frame_sequencer.sv | 165 ++++++++++++++++
 tb/tb_i2s_frame_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_frame_sequencer.sv
// Serial frame source: per row, a 16-bit header {nx_m1, ny_m1, 00, row} then W payload
// words fetched from a double-buffered frame memory; banks swap only between frames.
module i2s_frame_sequencer #(
  parameter int ROWS   = 32,
  parameter int ADDR_W = 14
) (
  input  logic              i2s_clk_i,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic [3:0]        cfg_nx_m1_i,
  input  logic [3:0]        cfg_ny_m1_i,
  input  logic              swap_req_i,
  output logic              swap_ack_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [15:0]       mem_rdata_i,
  output logic              i2s_data_o,
  output logic              row_start_o,
  output logic              frame_done_o,
  output logic              busy_o
);

  localparam int          OFF_W    = ADDR_W - 1;
  localparam logic [5:0]  ROW_LAST = 6'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_e;

  state_e            state_q;
  logic [3:0]        bit_q;
  logic [3:0]        x_q, y_q;
  logic [3:0]        nx_q, ny_q;
  logic [5:0]        row_q;
  logic [OFF_W-1:0]  off_q;
  logic              bank_q;
  logic [14:0]       sh_q;
  logic              data_q, rd_en_q, ack_q, row_start_q, frame_done_q, busy_q;
  logic [ADDR_W-1:0] addr_q;

  logic        last_bit, last_word, last_row, frame_end, start_frame;
  logic [15:0] hdr_frame, hdr_row;

  // The payload word count W = (nx+1)(ny+1) is walked as an x/y pair, so no multiply is needed.
  assign last_bit    = (bit_q == 4'd15);
  assign last_word   = (x_q == nx_q) && (y_q == ny_q);
  assign last_row    = (row_q == ROW_LAST);
  assign frame_end   = (state_q == S_PAYLOAD) && last_bit && last_word && last_row;
  assign start_frame = enable_i && ((state_q == S_IDLE) || frame_end);
  assign hdr_frame   = {cfg_nx_m1_i, cfg_ny_m1_i, 8'h00};
  assign hdr_row     = {nx_q, ny_q, 2'b00, row_q + 6'd1};

  // NOTE: every register here uses <= so all updates see pre-edge values, whatever the order.
  always_ff @(posedge i2s_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bit_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      nx_q         <= '0;
      ny_q         <= '0;
      row_q        <= '0;
      off_q        <= '0;
      bank_q       <= 1'b0;
      sh_q         <= '0;
      data_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      ack_q        <= 1'b0;
      row_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      addr_q       <= '0;
    end else begin
      rd_en_q      <= 1'b0;
      ack_q        <= 1'b0;
      row_start_q  <= 1'b0;
      frame_done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          data_q <= 1'b0;
          busy_q <= 1'b0;
        end

        S_HEADER: begin
          bit_q <= bit_q + 4'd1;
          if (bit_q == 4'd0) begin
            rd_en_q <= 1'b1;
            addr_q  <= {bank_q, off_q};
            off_q   <= off_q + OFF_W'(1);
          end
          if (last_bit) begin
            state_q <= S_PAYLOAD;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= mem_rdata_i[15];
            sh_q    <= mem_rdata_i[14:0];
          end else begin
            data_q <= sh_q[14];
            sh_q   <= {sh_q[13:0], 1'b0};
          end
        end

        S_PAYLOAD: begin
          bit_q <= bit_q + 4'd1;
          if (bit_q == 4'd14 && last_word && last_row) frame_done_q <= 1'b1;
          // Prefetch the next payload word; the header that follows the last word needs no read.
          if (bit_q == 4'd0 && !last_word) begin
            rd_en_q <= 1'b1;
            addr_q  <= {bank_q, off_q};
            off_q   <= off_q + OFF_W'(1);
          end
          if (!last_bit) begin
            data_q <= sh_q[14];
            sh_q   <= {sh_q[13:0], 1'b0};
          end else if (!last_word) begin
            if (x_q == nx_q) begin
              x_q <= '0;
              y_q <= y_q + 4'd1;
            end else begin
              x_q <= x_q + 4'd1;
            end
            data_q <= mem_rdata_i[15];
            sh_q   <= mem_rdata_i[14:0];
          end else if (!last_row) begin
            state_q     <= S_HEADER;
            row_q       <= row_q + 6'd1;
            data_q      <= hdr_row[15];
            sh_q        <= hdr_row[14:0];
            row_start_q <= 1'b1;
          end else begin
            bank_q  <= bank_q ^ swap_req_i;
            ack_q   <= swap_req_i;
            state_q <= S_IDLE;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end

        default: state_q <= S_IDLE;
      endcase

      // NOTE: placed after the case so that, being the later non-blocking write, it takes precedence.
      if (start_frame) begin
        state_q     <= S_HEADER;
        nx_q        <= cfg_nx_m1_i;
        ny_q        <= cfg_ny_m1_i;
        row_q       <= '0;
        bit_q       <= '0;
        off_q       <= '0;
        data_q      <= hdr_frame[15];
        sh_q        <= hdr_frame[14:0];
        row_start_q <= 1'b1;
        busy_q      <= 1'b1;
      end
    end
  end

  assign i2s_data_o   = data_q;
  assign mem_rd_en_o  = rd_en_q;
  assign mem_addr_o   = addr_q;
  assign swap_ack_o   = ack_q;
  assign row_start_o  = row_start_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Directed bench for i2s_frame_sequencer: captures serial units and compares them with
// hand-computed headers, payload words, addresses and handshake pulses.
module tb_i2s_frame_sequencer;

  localparam int ROWS   = 32;
  localparam int ADDR_W = 14;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [3:0]        cfg_nx, cfg_ny;
  logic              swap_req, swap_ack;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic              i2s_data, row_start, frame_done, busy;

  logic [15:0] mem [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int rs_prev = 0, rs_last = 0;
  int fd_prev = 0, fd_last = 0;
  int rd_count = 0;

  logic [15:0]       c_w;
  logic              c_rs0, c_rd1, c_fd15;
  logic [ADDR_W-1:0] c_a1;
  int                c_acks;

  i2s_frame_sequencer #(.ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .i2s_clk_i    (clk),
    .rst_n        (rst_n),
    .enable_i     (enable),
    .cfg_nx_m1_i  (cfg_nx),
    .cfg_ny_m1_i  (cfg_ny),
    .swap_req_i   (swap_req),
    .swap_ack_o   (swap_ack),
    .mem_rd_en_o  (mem_rd_en),
    .mem_addr_o   (mem_addr),
    .mem_rdata_i  (mem_rdata),
    .i2s_data_o   (i2s_data),
    .row_start_o  (row_start),
    .frame_done_o (frame_done),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: data valid the cycle after the strobe and held until the next read.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  always @(negedge clk) if (mem_rd_en) rd_count++;
  always @(negedge clk) if (row_start) begin rs_prev = rs_last; rs_last = cyc; end
  always @(negedge clk) if (frame_done) begin fd_prev = fd_last; fd_last = cyc; end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Capture one 16-cycle unit starting at its first bit and compare the word.
  task automatic unit(input string tag, input logic [15:0] exp);
    c_acks = 0;
    for (int i = 0; i < 16; i++) begin
      c_w[15-i] = i2s_data;
      if (i == 0) c_rs0 = row_start;
      if (i == 1) begin c_rd1 = mem_rd_en; c_a1 = mem_addr; end
      if (i == 15) c_fd15 = frame_done;
      if (swap_ack) c_acks++;
      tick();
    end
    check(tag, c_w, exp);
  endtask

  task automatic wait_frame_done(input string tag);
    int n = 0;
    while (!frame_done && n < 5000) begin
      tick();
      n++;
    end
    check(tag, frame_done, 1);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_snap;
    for (int a = 0; a < (1<<ADDR_W); a++) mem[a] = 16'(a) ^ 16'h4000;
    mem[0] = 16'hA5C3;
    mem[1] = 16'h0F0F;
    mem_rdata = 16'h0000;
    rst_n = 1'b0; enable = 1'b0; cfg_nx = 4'd0; cfg_ny = 4'd0; swap_req = 1'b0;

    // Reset state
    #12;
    check("rst_data", i2s_data, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_row_start", row_start, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_swap_ack", swap_ack, 0);
    @(negedge clk) rst_n = 1'b1;
    tick(2);
    check("idle_busy", busy, 0);

    // W=1 frame: headers, payload, prefetch in header bit 14
    enable = 1'b1;
    tick();
    check("start_busy", busy, 1);
    unit("f1_r0_hdr", 16'h0000);
    check("f1_r0_row_start", c_rs0, 1);
    check("f1_r0_rd_bit14", c_rd1, 1);
    check("f1_r0_addr", c_a1, 0);
    unit("f1_r0_pay", 16'hA5C3);
    check("f1_r0_pay_no_rd", c_rd1, 0);
    unit("f1_r1_hdr", 16'h0001);
    check("f1_r1_addr", c_a1, 1);
    unit("f1_r1_pay", 16'h0F0F);
    unit("f1_r2_hdr", 16'h0002);
    unit("f1_r2_pay", 16'h4002);
    tick(28 * 32);
    unit("f1_r31_hdr", 16'h001F);
    unit("f1_r31_pay", 16'h401F);
    check("f1_frame_done", c_fd15, 1);

    // Frame 2 back to back; swap requested mid-frame
    unit("f2_r0_hdr", 16'h0000);
    check("f2_r0_row_start", c_rs0, 1);
    check("f2_no_ack", c_acks, 0);
    unit("f2_r0_pay", 16'hA5C3);
    swap_req = 1'b1;
    unit("f2_r1_hdr", 16'h0001);
    check("f2_r1_bank0_addr", c_a1, 14'h0001);
    unit("f2_r1_pay", 16'h0F0F);
    wait_frame_done("f2_done");
    unit("f3_r0_hdr", 16'h0000);
    check("f3_swap_ack_once", c_acks, 1);
    check("f3_bank1_addr", c_a1, 14'h2000);
    swap_req = 1'b0;
    unit("f3_r0_pay", 16'h6000);

    // Config changed mid-frame: takes effect only next frame
    cfg_nx = 4'd1; cfg_ny = 4'd2;
    unit("f3_r1_hdr_old_cfg", 16'h0001);
    unit("f3_r1_pay", 16'h6001);
    wait_frame_done("f3_done");
    unit("f4_r0_hdr", 16'h1200);
    check("f4_r0_addr", c_a1, 14'h2000);
    tick(6 * 16 + 4 * 112);
    unit("f4_r5_hdr", 16'h1205);
    check("f4_r5_addr", c_a1, 14'h2000 + 14'd30);
    for (int k = 0; k < 6; k++) begin
      unit($sformatf("f4_r5_pay%0d", k), 16'h601E + 16'(k));
      check($sformatf("f4_r5_rd%0d", k), c_rd1, (k < 5) ? 1 : 0);
      if (k < 5) check($sformatf("f4_r5_addr%0d", k), c_a1, 14'h201F + 14'(k));
    end
    check("row_period", rs_last - rs_prev, 112);
    wait_frame_done("f4_done");
    check("frame_period", fd_last - fd_prev, 3584);

    // Enable dropped in row 10: frame completes, then idle with no reads
    tick(10 * 112 + 20);
    enable = 1'b0;
    tick(92 + 20 * 112);
    unit("f5_r31_hdr", 16'h121F);
    check("f5_r31_row_start", c_rs0, 1);
    tick(6 * 16 - 1);
    check("f5_frame_done", frame_done, 1);
    check("f5_busy_last", busy, 1);
    tick();
    check("stop_busy", busy, 0);
    check("stop_data", i2s_data, 0);
    check("stop_ack", swap_ack, 0);
    rd_snap = rd_count;
    tick(40);
    check("stop_no_reads", rd_count - rd_snap, 0);
    check("stop_no_row_start", rs_last < cyc - 40, 1);
    check("stop_busy_held", busy, 0);

    // Asynchronous reset in PAYLOAD, then restart on bank 0 with a new config
    enable = 1'b1;
    tick();
    unit("f6_r0_hdr", 16'h1200);
    check("f6_r0_addr", c_a1, 14'h2000);
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_addr", mem_addr, 0);
    check("arst_data", i2s_data, 0);
    check("arst_rd_en", mem_rd_en, 0);
    check("arst_row_start", row_start, 0);
    cfg_nx = 4'd3; cfg_ny = 4'd0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    unit("f7_r0_hdr", 16'h3000);
    check("f7_r0_row_start", c_rs0, 1);
    check("f7_bank0_addr", c_a1, 0);
    unit("f7_r0_pay", 16'hA5C3);
    check("f7_r0_pay_rd", c_rd1, 1);
    check("f7_r0_pay_addr", c_a1, 1);
    enable = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
